// File: rtl/seq_pkg.sv
// Shared definitions for the branch sequencer: opcode values, FSM states,
// the flag register layout and the branch-class decode helper.
package seq_pkg;

  localparam logic [5:0] OP_BLTZ = 6'b000111;
  localparam logic [5:0] OP_BZ   = 6'b001000;
  localparam logic [5:0] OP_BNZ  = 6'b001001;
  localparam logic [5:0] OP_BR   = 6'b001010;
  localparam logic [5:0] OP_BL   = 6'b001011;
  localparam logic [5:0] OP_BCY  = 6'b001100;
  localparam logic [5:0] OP_BNCY = 6'b001101;
  localparam logic [5:0] OP_BGEZ = 6'b001110;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_BRANCH = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic sign;
    logic carry;
    logic zero;
  } flags_t;

  // Branch opcodes occupy the contiguous range BLTZ..BGEZ.
  function automatic logic is_branch(input logic [5:0] op);
    return (op >= OP_BLTZ) && (op <= OP_BGEZ);
  endfunction

endpackage

// File: rtl/branch_sequencer_branch_cond.sv
// Branch condition evaluator: decides whether a branch opcode is taken
// given the current flag register contents.
module branch_cond
  import seq_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       sign,
  input  logic       carry,
  input  logic       zero,
  output logic       taken
);

  // Condition lookup; non-branch opcodes are never taken.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    taken = 1'b0;
    case (opcode)
      OP_BLTZ: taken = sign;
      OP_BZ:   taken = zero;
      OP_BNZ:  taken = ~zero;
      OP_BR:   taken = 1'b1;
      OP_BL:   taken = 1'b1;
      OP_BCY:  taken = carry;
      OP_BNCY: taken = ~carry;
      OP_BGEZ: taken = ~sign;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle instruction sequencer: owns the PC, fetches over a req/ack
// handshake, resolves branches locally and hands ALU work to the datapath
// with a start/done handshake guarded by a timeout.
module branch_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC     = '0,
  parameter int unsigned        EXEC_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic              flags_we,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              flag_zero,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  localparam int unsigned       CNT_W    = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EXEC_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

  state_t            state;
  state_t            state_next;
  flags_t            flag_reg;
  logic [CNT_W-1:0]  wait_cnt;
  logic              taken;
  logic              timeout;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] branch_target;

  assign opcode    = instr[31:26];
  assign imem_addr = pc;
  assign pc_inc    = pc + PC_STEP;
  // Word offset is sign-extended before the shift; PC math wraps silently.
  assign branch_offset = ADDR_W'({{14{instr[15]}}, instr[15:0], 2'b00});
  assign branch_target = pc_inc + branch_offset;
  assign link_data     = pc_inc;
  // Last permitted WAIT cycle: no exec_done here means the datapath is stuck.
  assign timeout       = (wait_cnt == CNT_LAST);

  branch_cond u_cond (
    .opcode (opcode),
    .sign   (flag_reg.sign),
    .carry  (flag_reg.carry),
    .zero   (flag_reg.zero),
    .taken  (taken)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    exec_start = 1'b0;
    link_we    = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_HALT)     state_next = S_HALT;
        else if (is_branch(opcode)) state_next = S_BRANCH;
        else                        state_next = S_EXEC;
      end
      S_BRANCH: begin
        link_we    = (opcode == OP_BL);
        state_next = S_FETCH;
      end
      S_EXEC: begin
        exec_start = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (exec_done)    state_next = S_FETCH;
        else if (timeout) state_next = S_HALT;
      end
      S_HALT:  halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  // PC, instruction latch, flag register, timeout counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= '0;
      flag_reg <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  if (imem_ack) instr <= imem_data;
        S_BRANCH: pc <= taken ? branch_target : pc_inc;
        S_EXEC:   wait_cnt <= '0;
        S_WAIT: begin
          if (exec_done) begin
            pc <= pc_inc;
            if (flags_we) flag_reg <= '{sign: flag_sign, carry: flag_carry, zero: flag_zero};
          end else if (timeout) begin
            err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: reset checks, a table of
// branch vectors, hand-written timeout/halt/reset sequences and a random
// instruction stream compared against a behavioural PC/flag model.
module tb_branch_sequencer;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        exec_start;
  logic        exec_done;
  logic        flags_we;
  logic        flag_sign;
  logic        flag_carry;
  logic        flag_zero;
  logic        link_we;
  logic [31:0] link_data;
  logic [31:0] pc;
  logic        halted;
  logic        err;

  branch_sequencer #(
    .ADDR_W       (32),
    .RESET_PC     (32'h0),
    .EXEC_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .instr      (instr),
    .opcode     (opcode),
    .exec_start (exec_start),
    .exec_done  (exec_done),
    .flags_we   (flags_we),
    .flag_sign  (flag_sign),
    .flag_carry (flag_carry),
    .flag_zero  (flag_zero),
    .link_we    (link_we),
    .link_data  (link_data),
    .pc         (pc),
    .halted     (halted),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state: architectural PC and flags {sign, carry, zero}.
  logic [31:0] m_pc;
  logic [2:0]  m_flags;
  logic [31:0] last_link;
  int          req_seen;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [15:0] imm;
    logic        fwe;
    logic [2:0]  flags;
    logic [31:0] exp_pc;
    logic [31:0] exp_link;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Branch rule table from the instruction set, flags = {sign, carry, zero}.
  function automatic logic m_is_branch(input logic [5:0] op);
    return (op >= 6'd7) && (op <= 6'd14);
  endfunction

  function automatic logic m_taken(input logic [5:0] op, input logic [2:0] fl);
    case (op)
      6'd7:    return fl[2];
      6'd8:    return fl[0];
      6'd9:    return !fl[0];
      6'd10:   return 1'b1;
      6'd11:   return 1'b1;
      6'd12:   return fl[1];
      6'd13:   return !fl[1];
      6'd14:   return !fl[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    imem_ack  = 1'b0;
    exec_done = 1'b0;
    flags_we  = 1'b0;
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_req", imem_req, 1);
    check("rst_start", exec_start, 0);
    check("rst_link_we", link_we, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_instr", instr, 32'h0);
    rst       = 1'b0;
    m_pc      = 32'h0;
    m_flags   = 3'b000;
    last_link = 32'h0;
  endtask

  // Drives one full instruction through fetch/decode/branch-or-exec, checking
  // every handshake step against the model. DUT must be in FETCH on entry.
  task automatic run_instr(input logic [31:0] word, input int ack_dly, input int done_dly,
                           input logic fwe, input logic [2:0] f, input logic done_in_exec);
    logic [5:0] op;
    op       = word[31:26];
    req_seen = 0;
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, m_pc);
    if (imem_req) req_seen++;
    imem_ack = 1'b0;
    repeat (ack_dly) begin
      step();
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, m_pc);
      if (imem_req) req_seen++;
    end
    imem_ack  = 1'b1;
    imem_data = word;
    step();
    imem_ack  = 1'b0;
    imem_data = $urandom;
    check("instr_latch", instr, word);
    check("opcode", 32'(opcode), 32'(op));
    check("req_drop", imem_req, 0);
    step();
    if (op == 6'h3F) begin
      check("halt_entry", halted, 1);
      return;
    end
    if (m_is_branch(op)) begin
      check("br_link_we", link_we, (op == 6'd11) ? 1 : 0);
      check("br_no_start", exec_start, 0);
      if (link_we) last_link = link_data;
      if (op == 6'd11) check("br_link_data", link_data, m_pc + 32'd4);
      if (m_taken(op, m_flags))
        m_pc = m_pc + 32'd4 + {{14{word[15]}}, word[15:0], 2'b00};
      else
        m_pc = m_pc + 32'd4;
      step();
      check("br_pc", pc, m_pc);
    end else begin
      check("exec_start", exec_start, 1);
      // A done in the EXEC cycle itself must be ignored, flags included.
      exec_done = done_in_exec;
      flags_we  = done_in_exec;
      {flag_sign, flag_carry, flag_zero} = ~f;
      step();
      exec_done = 1'b0;
      flags_we  = 1'b0;
      check("start_pulse", exec_start, 0);
      repeat (done_dly) step();
      check("wait_pc", pc, m_pc);
      check("wait_no_err", err, 0);
      exec_done = 1'b1;
      flags_we  = fwe;
      {flag_sign, flag_carry, flag_zero} = f;
      step();
      exec_done = 1'b0;
      flags_we  = 1'b0;
      m_pc = m_pc + 32'd4;
      if (fwe) m_flags = f;
      check("alu_pc", pc, m_pc);
    end
    check("next_fetch", imem_req, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_data  = 32'h0;
    exec_done  = 1'b0;
    flags_we   = 1'b0;
    flag_sign  = 1'b0;
    flag_carry = 1'b0;
    flag_zero  = 1'b0;
    m_pc       = 32'h0;
    m_flags    = 3'b000;
    last_link  = 32'h0;

    // Branch vectors: ALU op at 0x0 sets flags, branch then executes at 0x4.
    vecs[0]  = '{"bz_taken",   6'd8,  16'h0003, 1'b1, 3'b001, 32'h0000_0014, 32'h0};
    vecs[1]  = '{"bnz_not",    6'd9,  16'h0003, 1'b1, 3'b001, 32'h0000_0008, 32'h0};
    vecs[2]  = '{"bltz_taken", 6'd7,  16'h0001, 1'b1, 3'b100, 32'h0000_000C, 32'h0};
    vecs[3]  = '{"bltz_not",   6'd7,  16'h0001, 1'b1, 3'b000, 32'h0000_0008, 32'h0};
    vecs[4]  = '{"bgez_taken", 6'd14, 16'h0001, 1'b1, 3'b000, 32'h0000_000C, 32'h0};
    vecs[5]  = '{"bgez_not",   6'd14, 16'h0001, 1'b1, 3'b100, 32'h0000_0008, 32'h0};
    vecs[6]  = '{"bcy_taken",  6'd12, 16'h0002, 1'b1, 3'b010, 32'h0000_0010, 32'h0};
    vecs[7]  = '{"bncy_not",   6'd13, 16'h0002, 1'b1, 3'b010, 32'h0000_0008, 32'h0};
    vecs[8]  = '{"bncy_taken", 6'd13, 16'h0002, 1'b1, 3'b000, 32'h0000_0010, 32'h0};
    vecs[9]  = '{"bcy_no_we",  6'd12, 16'h0005, 1'b0, 3'b010, 32'h0000_0008, 32'h0};
    vecs[10] = '{"br_back",    6'd10, 16'hFFFE, 1'b1, 3'b000, 32'h0000_0000, 32'h0};
    vecs[11] = '{"br_wrap",    6'd10, 16'hFFFD, 1'b1, 3'b111, 32'hFFFF_FFFC, 32'h0};
    vecs[12] = '{"bl_fwd",     6'd11, 16'h0004, 1'b1, 3'b000, 32'h0000_0018, 32'h0000_0008};
    vecs[13] = '{"bnz_max",    6'd9,  16'h7FFF, 1'b1, 3'b000, 32'h0002_0004, 32'h0};
    vecs[14] = '{"bz_min",     6'd8,  16'h8000, 1'b1, 3'b001, 32'hFFFE_0008, 32'h0};

    // Ack after two idle request cycles, done three WAIT cycles later.
    do_reset();
    run_instr(32'h0000_0000, 2, 3, 1'b0, 3'b000, 1'b0);
    check("t1_req_cycles", 32'(req_seen), 32'd3);
    check("t1_pc", pc, 32'h0000_0004);

    foreach (vecs[i]) begin
      do_reset();
      run_instr(32'h0000_0000, 0, 1, vecs[i].fwe, vecs[i].flags, 1'b0);
      run_instr({vecs[i].op, 10'h0, vecs[i].imm}, 0, 0, 1'b0, 3'b000, 1'b0);
      check(vecs[i].name, pc, vecs[i].exp_pc);
      check({vecs[i].name, "_link"}, last_link, vecs[i].exp_link);
    end

    // BL with offset -1 word at 0x20 returns to itself and links 0x24.
    do_reset();
    run_instr({6'd10, 10'h0, 16'h0007}, 1, 0, 1'b0, 3'b000, 1'b0);
    check("t3_setup_pc", pc, 32'h0000_0020);
    run_instr({6'd11, 10'h0, 16'hFFFF}, 0, 0, 1'b0, 3'b000, 1'b0);
    check("t3_link", last_link, 32'h0000_0024);
    check("t3_pc", pc, 32'h0000_0020);

    // Exec timeout: no done ever; halt exactly after TO WAIT cycles.
    do_reset();
    imem_ack  = 1'b1;
    imem_data = 32'h0400_0000;
    step();
    imem_ack  = 1'b0;
    step();
    check("to_start", exec_start, 1);
    step();
    repeat (TO - 1) step();
    check("to_not_yet_halted", halted, 0);
    check("to_not_yet_err", err, 0);
    step();
    check("to_halted", halted, 1);
    check("to_err", err, 1);
    imem_ack = 1'b1;
    repeat (3) step();
    imem_ack = 1'b0;
    check("to_pc_frozen", pc, 32'h0);
    check("to_no_req", imem_req, 0);
    check("to_err_sticky", err, 1);
    do_reset();

    // HALT instruction freezes everything until reset.
    run_instr({6'd10, 10'h0, 16'h0002}, 0, 0, 1'b0, 3'b000, 1'b0);
    run_instr(32'hFC00_0000, 0, 0, 1'b0, 3'b000, 1'b0);
    repeat (4) step();
    check("halt_pc_frozen", pc, m_pc);
    check("halt_no_req", imem_req, 0);
    check("halt_no_start", exec_start, 0);
    check("halt_no_err", err, 0);
    do_reset();

    // Reset in WAIT abandons the instruction.
    run_instr({6'd10, 10'h0, 16'h0003}, 0, 0, 1'b0, 3'b000, 1'b0);
    imem_ack  = 1'b1;
    imem_data = 32'h0800_0000;
    step();
    imem_ack  = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_wait_pc", pc, 32'h0);
    check("rst_wait_req", imem_req, 1);
    check("rst_wait_start", exec_start, 0);
    check("rst_wait_halted", halted, 0);
    m_pc = 32'h0;
    m_flags = 3'b000;

    // Reset coinciding with an ack in FETCH discards the fetched word.
    run_instr({6'd10, 10'h0, 16'h0003}, 0, 0, 1'b0, 3'b000, 1'b0);
    rst       = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'h2C00_0005;
    step();
    rst      = 1'b0;
    imem_ack = 1'b0;
    check("rst_fetch_instr", instr, 32'h0);
    check("rst_fetch_pc", pc, 32'h0);
    check("rst_fetch_req", imem_req, 1);
    check("rst_fetch_link", link_we, 0);
    m_pc = 32'h0;
    m_flags = 3'b000;

    // Random instruction stream against the model.
    for (int n = 0; n < 250; n++) begin
      logic [5:0]  op;
      logic [31:0] word;
      if ($urandom_range(0, 2) == 0) begin
        op = 6'($urandom_range(0, 62));
        while (m_is_branch(op)) op = 6'($urandom_range(0, 62));
      end else begin
        op = 6'(7 + $urandom_range(0, 7));
      end
      word = {op, 10'($urandom), 16'($urandom)};
      run_instr(word, $urandom_range(0, 3), $urandom_range(0, TO - 1),
                1'($urandom), 3'($urandom), 1'($urandom));
    end
    check("rand_final_pc", pc, m_pc);
    check("rand_final_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
